key_report_tx: RTL and testbench
================================

KEY_REPORT_TX -- requirements
Module: key_report_tx

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 40: width of key_down, 1..256.
REQ-002 SHALL have parameter HEADER, default 8'hA5: first byte of every frame.
REQ-003 SHALL have parameter KEEPALIVE, default 0: idle cycles before an unforced resend; 0 disables it.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port key_down, input, NUM_KEYS: live key state, bit i = key i pressed.
REQ-007 SHALL have port force, input, 1: one-cycle request to send the current state.
REQ-008 SHALL have port uart_send, output, 1: byte-valid request to the UART byte transmitter.
REQ-009 SHALL have port uart_data, output, 8: byte being offered.
REQ-010 SHALL have port uart_send_done, input, 1: one-cycle pulse when the transmitter finishes a byte.
REQ-011 SHALL have port busy, output, 1: high while a frame is in progress.
REQ-012 SHALL have port frame_cnt, output, 8: completed-frame count, wraps 255->0.
REQ-013 SHALL have port sta, output, 4: encoded FSM state for seven-segment debug.

Function
REQ-014 SHALL define NB = ceil(NUM_KEYS/8) data bytes.
REQ-015 SHALL send each frame as HEADER, then data bytes, then CHK; data bytes go least-significant first (byte0 = keys[7:0]); unused top bits are zero.
REQ-016 SHALL compute CHK as the mod-256 sum of HEADER and all NB data bytes.
REQ-017 SHALL use FSM states IDLE(0), LOAD(1), SEND(2), WAIT(3), GAP(4); sta shows the state code.
REQ-018 SHALL, in IDLE, trigger on any of: key_down != last_sent, force, or pending_force, or keepalive counter = KEEPALIVE-1 when KEEPALIVE>0.
REQ-019 SHALL, on a trigger in cycle N, latch key_down into frame_buf and last_sent, clear pending_force, clear the keepalive counter, and move to LOAD; busy SHALL be high from cycle N+1.
REQ-020 SHALL, in LOAD, set byte index to 0 and uart_data to HEADER, then move to SEND; uart_send SHALL first go high in cycle N+2.
REQ-021 SHALL, in SEND/WAIT, hold uart_send=1 with uart_data stable until uart_send_done is sampled high.
REQ-022 SHALL, on uart_send_done in WAIT, move to GAP with uart_send=0 for exactly one cycle, then present the next byte and return to SEND.
REQ-023 SHALL, after the CHK byte's uart_send_done, increment frame_cnt, drop busy, and go to IDLE.
REQ-024 SHALL ignore uart_send_done outside WAIT.
REQ-025 SHALL read frame contents only from frame_buf; key_down changes during a frame SHALL NOT alter bytes in flight.
REQ-026 SHALL detect key_down changes during a frame in IDLE after the frame ends and start a new frame; at least one IDLE cycle SHALL separate frames.
REQ-027 SHALL, on force while busy, set pending_force; multiple forces SHALL collapse into one extra frame.
REQ-028 SHALL, when force and a change coincide, send exactly one frame.
REQ-029 SHALL increment the keepalive counter only in IDLE and saturate it at KEEPALIVE-1.

Reset
REQ-030 SHALL, with rst high at a clock edge, set state=IDLE, uart_send=0, uart_data=0, busy=0, frame_cnt=0, last_sent=0, frame_buf=0, pending_force=0, byte index=0, keepalive counter=0.
REQ-031 SHALL abort a frame in progress when rst is asserted; uart_send SHALL be 0 in the cycle after the reset edge; the partial frame SHALL NOT count.
REQ-032 SHALL, once rst is released, send a frame if key_down != 0, because last_sent=0.

Verification
REQ-033 SHALL be tested: NUM_KEYS=40, KEEPALIVE=0, key_down=0, 200 cycles -> uart_send never high, busy=0, frame_cnt=0.
REQ-034 SHALL be tested: key_down=40'h0000000001, done pulses 3 cycles after each send -> bytes A5,01,00,00,00,00,A6; frame_cnt=1; exactly one GAP cycle between bytes.
REQ-035 SHALL be tested: during byte 2 of a frame for 40'h01, set key_down=40'h8000000000 -> first frame unchanged (A5,01,00,00,00,00,A6), then frame A5,00,00,00,00,80,25; frame_cnt=2.
REQ-036 SHALL be tested: three force pulses while busy, key_down constant -> exactly one extra identical frame.
REQ-037 SHALL be tested: rst pulsed while in WAIT on byte 3 -> next cycle uart_send=0, sta=0, frame_cnt=0; with key_down unchanged and nonzero, a full new frame follows.
REQ-038 SHALL be tested: NUM_KEYS=12, KEEPALIVE=50, key_down=12'hFFF -> frame A5,FF,0F,B3; key_down held -> identical frame repeats every 50 idle cycles.

Source files
------------

// File: rtl/key_report_tx.sv
// Key-matrix report transmitter: frames the live key state as HEADER, data
// bytes (LSB first) and a mod-256 checksum, one byte at a time to a UART.
module key_report_tx #(
    parameter int          NUM_KEYS  = 40,
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int          KEEPALIVE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_down,
    input  logic                force_send,
    output logic                uart_send,
    output logic [7:0]          uart_data,
    input  logic                uart_send_done,
    output logic                busy,
    output logic [7:0]          frame_cnt,
    output logic [3:0]          sta
);

    localparam int NB    = (NUM_KEYS + 7) / 8;
    localparam int PAD_W = NB * 8;
    localparam int IDX_W = 6;
    localparam int KA_W  = (KEEPALIVE > 1) ? $clog2(KEEPALIVE) : 1;
    localparam logic [KA_W-1:0]  KA_MAX   = (KEEPALIVE > 0) ? KA_W'(KEEPALIVE - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB + 1);
    localparam logic [IDX_W-1:0] IDX_NB   = IDX_W'(NB);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PAD_W-1:0]     frame_buf;
    logic [NUM_KEYS-1:0]  last_sent;
    logic                 pending_force;
    logic [IDX_W-1:0]     byte_idx;
    logic [KA_W-1:0]      ka_cnt;
    logic [7:0]           chk;
    logic [7:0]           next_data;
    logic                 ka_hit;
    logic                 trigger;
    logic                 last_byte;

    // byte_idx names the byte on the wire: 0 = header, 1..NB = data, NB+1 = checksum
    assign ka_hit    = (KEEPALIVE > 0) && (ka_cnt == KA_MAX);
    assign trigger   = (key_down != last_sent) || force_send || pending_force || ka_hit;
    assign last_byte = (byte_idx == IDX_LAST);
    assign next_data = 8'(frame_buf >> {byte_idx, 3'b000});

    assign uart_send = (state == SEND) || (state == WAIT);
    assign busy      = (state != IDLE);
    assign sta       = {1'b0, state};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (trigger) state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    state_next = WAIT;
            WAIT:    if (uart_send_done) state_next = last_byte ? IDLE : GAP;
            GAP:     state_next = SEND;
            default: state_next = IDLE;
        endcase
    end

    // The checksum accumulates as each data byte is staged, so it is complete
    // by the time the GAP before the final byte selects it.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_data     <= 8'd0;
            frame_cnt     <= 8'd0;
            frame_buf     <= '0;
            last_sent     <= '0;
            pending_force <= 1'b0;
            byte_idx      <= '0;
            ka_cnt        <= '0;
            chk           <= 8'd0;
        end else begin
            if (force_send && state != IDLE) begin
                pending_force <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        frame_buf     <= PAD_W'(key_down);
                        last_sent     <= key_down;
                        pending_force <= 1'b0;
                        ka_cnt        <= '0;
                    end else if (ka_cnt != KA_MAX) begin
                        ka_cnt <= ka_cnt + KA_W'(1);
                    end
                end
                LOAD: begin
                    byte_idx  <= '0;
                    uart_data <= HEADER;
                    chk       <= HEADER;
                end
                WAIT: begin
                    if (uart_send_done && last_byte) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                GAP: begin
                    byte_idx <= byte_idx + IDX_W'(1);
                    if (byte_idx < IDX_NB) begin
                        uart_data <= next_data;
                        chk       <= chk + next_data;
                    end else begin
                        uart_data <= chk;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_report_tx.sv
// Randomized scoreboard bench for key_report_tx: stimulus pushes expected frame
// bytes, a monitor pops and compares them as the DUT offers each byte.
module tb_key_report_tx;

    localparam int FRAME_LEN = 7;

    logic        clk;
    logic        rst;
    logic [39:0] key_down;
    logic        force_send;
    logic        uart_send;
    logic [7:0]  uart_data;
    logic        uart_send_done;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [3:0]  sta;

    logic        rst_ka;
    logic [11:0] key_down_ka;
    logic        force_ka;
    logic        uart_send_ka;
    logic [7:0]  uart_data_ka;
    logic        uart_send_done_ka;
    logic        busy_ka;
    logic [7:0]  frame_cnt_ka;
    logic [3:0]  sta_ka;

    int          checks;
    int          errors;
    logic [7:0]  exp_q[$];
    int          model_frames;
    logic [39:0] model_last;
    bit          resp_rand;

    key_report_tx #(.NUM_KEYS(40), .HEADER(8'hA5), .KEEPALIVE(0)) dut (
        .clk(clk), .rst(rst), .key_down(key_down), .force_send(force_send),
        .uart_send(uart_send), .uart_data(uart_data), .uart_send_done(uart_send_done),
        .busy(busy), .frame_cnt(frame_cnt), .sta(sta)
    );

    key_report_tx #(.NUM_KEYS(12), .HEADER(8'hA5), .KEEPALIVE(50)) dut_ka (
        .clk(clk), .rst(rst_ka), .key_down(key_down_ka), .force_send(force_ka),
        .uart_send(uart_send_ka), .uart_data(uart_data_ka), .uart_send_done(uart_send_done_ka),
        .busy(busy_ka), .frame_cnt(frame_cnt_ka), .sta(sta_ka)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // A frame is the header, the five key bytes low first, then their sum.
    task automatic pushFrame(input logic [39:0] k);
        int sum;
        logic [7:0] b;
        sum = 'hA5;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 5; i++) begin
            b = k[i*8 +: 8];
            exp_q.push_back(b);
            sum += int'(b);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic waitIdle();
        int consec;
        bit timed_out;
        consec = 0;
        for (int c = 0; c < 800 && consec < 5; c++) begin
            @(negedge clk);
            if (!busy) consec++;
            else consec = 0;
        end
        timed_out = (consec < 5);
        checkOutput("idle_timeout", 64'(timed_out), 0);
        checkOutput("frame_cnt", frame_cnt, 8'(model_frames));
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        checkOutput("idle_sta", sta, 0);
    endtask

    // One episode: a triggering key change (optionally with force), then an
    // optional mid-frame change and a burst of forces while the frame is busy.
    task automatic applyStimulus(input logic [39:0] k1, input bit f1, input logic [39:0] k2,
                                 input int nforce, input int change_wait);
        @(posedge clk); #1;
        key_down   = k1;
        force_send = f1;
        pushFrame(k1);
        model_frames++;
        @(negedge clk);
        checkOutput("busy_at_trigger", busy, 0);
        @(posedge clk); #1;
        force_send = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_trigger", busy, 1);
        checkOutput("send_in_load", uart_send, 0);
        checkOutput("sta_load", sta, 1);
        @(negedge clk);
        checkOutput("send_first_byte", uart_send, 1);
        checkOutput("sta_send", sta, 2);
        repeat (change_wait) @(posedge clk);
        #1;
        key_down = k2;
        for (int i = 0; i < nforce; i++) begin
            @(posedge clk); #1;
            force_send = 1'b1;
            @(posedge clk); #1;
            force_send = 1'b0;
        end
        if (k2 != k1 || nforce > 0) begin
            pushFrame(k2);
            model_frames++;
        end
        model_last = k2;
        waitIdle();
    endtask

    // Transmitter model: done pulses d cycles after each new byte request.
    initial begin
        int  r_cnt;
        bit  r_armed;
        bit  r_prev;
        uart_send_done = 1'b0;
        r_cnt = 0; r_armed = 0; r_prev = 0;
        forever begin
            @(posedge clk); #2;
            uart_send_done = 1'b0;
            if (rst) begin
                r_armed = 0;
            end else if (r_armed) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    uart_send_done = 1'b1;
                    r_armed = 0;
                end
            end else if (uart_send && !r_prev) begin
                r_armed = 1;
                r_cnt = resp_rand ? int'($urandom_range(1, 5)) : 3;
            end
            r_prev = uart_send;
        end
    end

    initial begin
        int  r_cnt;
        bit  r_armed;
        bit  r_prev;
        uart_send_done_ka = 1'b0;
        r_cnt = 0; r_armed = 0; r_prev = 0;
        forever begin
            @(posedge clk); #2;
            uart_send_done_ka = 1'b0;
            if (rst_ka) begin
                r_armed = 0;
            end else if (r_armed) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    uart_send_done_ka = 1'b1;
                    r_armed = 0;
                end
            end else if (uart_send_ka && !r_prev) begin
                r_armed = 1;
                r_cnt = 2;
            end
            r_prev = uart_send_ka;
        end
    end

    logic [7:0] mon_byte;
    int         mon_pos;
    initial begin
        bit mon_prev;
        int gap_low;
        logic [7:0] exp_b;
        mon_prev = 0; mon_pos = 0; gap_low = 0; mon_byte = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pos = 0;
            end else if (uart_send && !mon_prev) begin
                checkOutput("byte_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    checkOutput("frame_byte", uart_data, exp_b);
                end
                if (mon_pos != 0) checkOutput("gap_cycles", gap_low, 1);
                gap_low = 0;
                mon_byte = uart_data;
                mon_pos = (mon_pos + 1) % FRAME_LEN;
            end else if (uart_send) begin
                checkOutput("data_stable", uart_data, mon_byte);
            end
            if (!uart_send) gap_low++;
            mon_prev = uart_send;
        end
    end

    // Keepalive instance: the same frame must recur after exactly 50 idle cycles.
    bit ka_done;
    initial begin
        logic [7:0] ka_exp [4];
        bit ka_prev;
        bit ka_busy_prev;
        int ka_pos;
        int ka_frames;
        int ka_idle;
        ka_exp = '{8'hA5, 8'hFF, 8'h0F, 8'hB3};
        ka_prev = 0; ka_busy_prev = 0; ka_pos = 0; ka_frames = 0; ka_idle = 0; ka_done = 0;
        rst_ka = 1'b1;
        key_down_ka = 12'hFFF;
        force_ka = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ka = 1'b0;
        while (!ka_done) begin
            @(negedge clk);
            if (busy_ka && !ka_busy_prev) begin
                if (ka_frames > 0) checkOutput("ka_idle_cycles", ka_idle, 50);
                ka_idle = 0;
            end
            if (!busy_ka) ka_idle++;
            if (uart_send_ka && !ka_prev) begin
                checkOutput("ka_byte", uart_data_ka, ka_exp[ka_pos]);
                ka_pos++;
                if (ka_pos == 4) begin
                    ka_pos = 0;
                    ka_frames++;
                    if (ka_frames == 3) ka_done = 1;
                end
            end
            ka_prev = uart_send_ka;
            ka_busy_prev = busy_ka;
        end
    end

    initial begin
        int send_hi;
        int busy_hi;
        bit found;
        logic [31:0] r_lo;
        logic [31:0] r_hi;
        logic [39:0] k1;
        logic [39:0] k2;
        bit f1;
        checks = 0; errors = 0;
        model_frames = 0; model_last = '0;
        resp_rand = 0;
        rst = 1'b1; key_down = '0; force_send = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_send", uart_send, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_cnt", frame_cnt, 0);
        checkOutput("reset_sta", sta, 0);
        checkOutput("reset_data", uart_data, 0);
        @(posedge clk); #1 rst = 1'b0;

        send_hi = 0; busy_hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_send) send_hi++;
            if (busy) busy_hi++;
        end
        checkOutput("idle_send_cycles", send_hi, 0);
        checkOutput("idle_busy_cycles", busy_hi, 0);
        checkOutput("idle_frame_cnt", frame_cnt, 0);

        applyStimulus(40'h00_0000_0001, 0, 40'h00_0000_0001, 0, 0);
        applyStimulus(40'h00_0000_0001, 1, 40'h80_0000_0000, 0, 10);
        applyStimulus(40'h00_0000_1234, 0, 40'h00_0000_1234, 3, 2);

        // Abort a frame while its fourth byte is awaiting done.
        @(posedge clk); #1;
        key_down = 40'hA1_B2C3_D4E5;
        pushFrame(key_down);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #1;
            if (mon_pos == 4) found = 1;
        end
        checkOutput("reach_byte3_timeout", 64'(!found), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_frames = 0;
        pushFrame(key_down);
        model_frames = 1;
        model_last = key_down;
        @(negedge clk);
        checkOutput("abort_send", uart_send, 0);
        checkOutput("abort_sta", sta, 0);
        checkOutput("abort_frame_cnt", frame_cnt, 0);
        waitIdle();

        resp_rand = 1;
        for (int ep = 0; ep < 20; ep++) begin
            r_lo = $urandom; r_hi = $urandom;
            k1 = {r_hi[7:0], r_lo};
            f1 = bit'($urandom_range(0, 1));
            if (k1 == model_last) f1 = 1;
            if ($urandom_range(0, 1) == 1) begin
                r_lo = $urandom; r_hi = $urandom;
                k2 = {r_hi[7:0], r_lo};
                if (k2 == k1) k2 = ~k1;
            end else begin
                k2 = k1;
            end
            applyStimulus(k1, f1, k2, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)));
        end

        for (int c = 0; c < 2000 && !ka_done; c++) @(posedge clk);
        checkOutput("ka_complete", 64'(ka_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
